ins_mem_backing: RTL and testbench

- Multi-cycle instruction memory that sits directly downstream of the instruction cache.
- Serves 128-bit block fills over the cache's memread / mem_address / mem_readdata / mem_busywait handshake.
- Models a slow main memory: fixed, parameterised access latency, no pipelining, one outstanding request.
- Read-only from the processor's point of view.

---
 rtl/ins_mem_backing.sv | 106 ++++++++++
 tb/tb_ins_mem_backing.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ins_mem_backing.sv
// +----------------------------------------------------------------------------+
// | Module      : ins_mem_backing                                              |
// | Description : Multi-cycle, read-only backing store for the instruction     |
// |               cache (128-bit block fills). Optional INS_MEM_READCNT_EN     |
// |               adds a saturating completed-read counter (read_count).       |
// | Revision    : 1.1                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module ins_mem_backing #(
    parameter int    LATENCY   = 4,
    parameter string INIT_FILE = "instr_mem.hex"
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         memread,
    input  logic [5:0]   mem_address,
    output logic [127:0] mem_readdata,
    output logic         mem_busywait
`ifdef INS_MEM_READCNT_EN
    ,
    output logic [15:0]  read_count
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [7:0] C_LAST = 8'(LATENCY - 1);

    logic [1:0]   r_state;
    logic [1:0]   w_next_state;
    logic [7:0]   r_count;
    logic [5:0]   r_addr;
    logic [127:0] r_readdata;
    logic [7:0]   r_mem [0:255];
    logic [127:0] w_block;
    logic         w_last;
    logic         w_unused_addr_hi;

    if (LATENCY < 1 || LATENCY > 255) begin : g_bad_latency
        initial $error("ins_mem_backing: LATENCY=%0d outside 1..255", LATENCY);
    end

    assign w_unused_addr_hi = ^r_addr[5:4];

    for (genvar k = 0; k < 16; k++) begin : g_block_bytes
        assign w_block[8*k +: 8] = r_mem[{r_addr[3:0], 4'(k)}];
    end

    always_comb begin
        w_next_state = r_state;
        w_last       = (r_count == C_LAST);
        case (r_state)
            S_IDLE:  if (memread) w_next_state = S_BUSY;
            S_BUSY:  if (w_last) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    assign mem_busywait = RESET & (((r_state == S_IDLE) & memread) | (r_state == S_BUSY));
    assign mem_readdata = r_readdata;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state    <= S_IDLE;
            r_count    <= 8'd0;
            r_addr     <= 6'd0;
            r_readdata <= 128'd0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (memread) begin
                        r_addr  <= mem_address;
                        r_count <= 8'd0;
                    end
                end
                S_BUSY: begin
                    r_count <= r_count + 8'd1;
                    if (w_last) r_readdata <= w_block;
                end
                default: ;
            endcase
        end
    end

`ifdef INS_MEM_READCNT_EN
    logic [15:0] r_read_count;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_read_count <= 16'd0;
        end else if (r_state == S_BUSY && w_last && r_read_count != 16'hFFFF) begin
            r_read_count <= r_read_count + 16'd1;
        end
    end

    assign read_count = r_read_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ins_mem_backing.sv
// Self-checking bench for ins_mem_backing: random image, random reads, reset and handshake corner cases.
`default_nettype none

module tb_ins_mem_backing;

  localparam int LAT = 4;

  logic         CLK = 1'b0;
  logic         RESET = 1'b0;
  logic         memread = 1'b0;
  logic [5:0]   mem_address = 6'd0;
  logic [127:0] mem_readdata;
  logic         mem_busywait;
`ifdef INS_MEM_READCNT_EN
  logic [15:0]  read_count;
`endif

  int total = 0;
  int bad   = 0;
  logic [7:0] model_mem [256];

  always #5 CLK = ~CLK;

  ins_mem_backing #(
    .LATENCY   (LAT),
    .INIT_FILE ("")
  ) u_dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .memread      (memread),
    .mem_address  (mem_address),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait)
`ifdef INS_MEM_READCNT_EN
    ,
    .read_count   (read_count)
`endif
  );

  // Reference: block b is bytes 16b..16b+15 of a 256-byte store, little-endian, address wraps mod 256.
  function automatic logic [127:0] exp_block(input logic [5:0] a);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = model_mem[(16 * int'(a) + k) % 256];
    return r;
  endfunction

  task automatic load_image();
    for (int i = 0; i < 256; i++) model_mem[i] = 8'($urandom_range(0, 255));
    for (int k = 0; k < 16; k++) model_mem[80 + k] = 8'(8'h50 + k);
    model_mem[240] = ~model_mem[32];
    for (int i = 0; i < 256; i++) u_dut.r_mem[i] = model_mem[i];
  endtask

  // Issues one request and returns whether busywait rose combinationally, the edge count until it fell, and the data.
  task automatic run_read(input logic [5:0] a, input logic [5:0] a2, input bit drop,
                          output bit early, output int edges, output logic [127:0] d);
    @(negedge CLK);
    memread = 1'b1;
    mem_address = a;
    #1 early = mem_busywait;
    @(posedge CLK);
    edges = 0;
    @(negedge CLK);
    mem_address = a2;
    if (drop) memread = 1'b0;
    while (mem_busywait === 1'b1 && edges < 300) begin
      @(posedge CLK);
      edges++;
      @(negedge CLK);
    end
    d = mem_readdata;
    memread = 1'b0;
  endtask

  task automatic test_reset();
    memread = 1'b1;
    mem_address = 6'h05;
    repeat (2) @(negedge CLK);
    total++;
    if (mem_busywait !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", mem_busywait); end
    total++;
    if (mem_readdata !== 128'd0) begin bad++; $display("FAIL reset_data: got %h expected 0", mem_readdata); end
    RESET = 1'b1;
    #1;
    total++;
    if (mem_busywait !== 1'b1) begin bad++; $display("FAIL reset_release_busy: got %b expected 1", mem_busywait); end
    memread = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_single();
    bit early; int edges; logic [127:0] d;
    run_read(6'h05, 6'h05, 1'b0, early, edges, d);
    total++;
    if (early !== 1'b1) begin bad++; $display("FAIL single_early_busy: got %b expected 1", early); end
    total++;
    if (edges != LAT) begin bad++; $display("FAIL single_latency: got %0d expected %0d", edges, LAT); end
    total++;
    if (d !== 128'h5F5E5D5C5B5A59585756555453525150) begin
      bad++; $display("FAIL single_data: got %h expected %h", d, 128'h5F5E5D5C5B5A59585756555453525150);
    end
    @(negedge CLK);
    total++;
    if (mem_busywait !== 1'b0) begin bad++; $display("FAIL single_idle_busy: got %b expected 0", mem_busywait); end
    total++;
    if (mem_readdata !== 128'h5F5E5D5C5B5A59585756555453525150) begin
      bad++; $display("FAIL single_hold: got %h expected block 5", mem_readdata);
    end
    memread = 1'b1;
    #1;
    total++;
    if (mem_busywait !== 1'b1) begin bad++; $display("FAIL single_back_to_idle: got %b expected 1", mem_busywait); end
    memread = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_addr_change();
    bit early; int edges; logic [127:0] d;
    run_read(6'h02, 6'h3F, 1'b1, early, edges, d);
    total++;
    if (edges != LAT) begin bad++; $display("FAIL addr_change_latency: got %0d expected %0d", edges, LAT); end
    total++;
    if (d !== exp_block(6'h02)) begin bad++; $display("FAIL addr_change_data: got %h expected %h", d, exp_block(6'h02)); end
  endtask

  task automatic test_back_to_back();
    int edges; int unstable; logic [127:0] d1;
    @(negedge CLK);
    memread = 1'b1;
    mem_address = 6'h01;
    @(posedge CLK);
    edges = 0;
    @(negedge CLK);
    while (mem_busywait === 1'b1 && edges < 300) begin @(posedge CLK); edges++; @(negedge CLK); end
    d1 = mem_readdata;
    total++;
    if (edges != LAT) begin bad++; $display("FAIL b2b_latency1: got %0d expected %0d", edges, LAT); end
    total++;
    if (d1 !== exp_block(6'h01)) begin bad++; $display("FAIL b2b_data1: got %h expected %h", d1, exp_block(6'h01)); end
    mem_address = 6'h00;
    @(negedge CLK);
    total++;
    if (mem_busywait !== 1'b1) begin bad++; $display("FAIL b2b_idle_rise: got %b expected 1", mem_busywait); end
    @(posedge CLK);
    edges = 0;
    unstable = 0;
    @(negedge CLK);
    while (mem_busywait === 1'b1 && edges < 300) begin
      if (mem_readdata !== d1) unstable++;
      @(posedge CLK);
      edges++;
      @(negedge CLK);
    end
    total++;
    if (unstable != 0) begin bad++; $display("FAIL b2b_stable: got %0d changes expected 0", unstable); end
    total++;
    if (edges != LAT) begin bad++; $display("FAIL b2b_latency2: got %0d expected %0d", edges, LAT); end
    total++;
    if (mem_readdata !== exp_block(6'h00)) begin
      bad++; $display("FAIL b2b_data2: got %h expected %h", mem_readdata, exp_block(6'h00));
    end
    memread = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_reset_mid();
    bit early; int edges; logic [127:0] d;
    logic [5:0] a, b;
    a = 6'($urandom_range(0, 63));
    b = 6'($urandom_range(0, 63));
    @(negedge CLK);
    memread = 1'b1;
    mem_address = a;
    @(posedge CLK);
    memread = 1'b0;
    repeat (2) @(posedge CLK);
    #2 RESET = 1'b0;
    #1;
    total++;
    if (mem_busywait !== 1'b0) begin bad++; $display("FAIL reset_mid_busy: got %b expected 0", mem_busywait); end
    total++;
    if (mem_readdata !== 128'd0) begin bad++; $display("FAIL reset_mid_data: got %h expected 0", mem_readdata); end
    @(negedge CLK);
    RESET = 1'b1;
    run_read(b, b, 1'b0, early, edges, d);
    total++;
    if (edges != LAT || d !== exp_block(b)) begin
      bad++; $display("FAIL reset_mid_after: got %0d/%h expected %0d/%h", edges, d, LAT, exp_block(b));
    end
    run_read(a, a, 1'b0, early, edges, d);
    total++;
    if (d !== exp_block(a)) begin bad++; $display("FAIL reset_mid_array: got %h expected %h", d, exp_block(a)); end
  endtask

  task automatic test_random();
    bit early; int edges; logic [127:0] d;
    logic [5:0] a, a2;
    for (int n = 0; n < 8; n++) begin
      a  = 6'($urandom_range(0, 63));
      a2 = 6'($urandom_range(0, 63));
      repeat ($urandom_range(0, 3)) @(negedge CLK);
      run_read(a, a2, 1'($urandom_range(0, 1)), early, edges, d);
      total++;
      if (early !== 1'b1 || edges != LAT) begin
        bad++; $display("FAIL random_timing[%0d]: got early=%b edges=%0d expected 1/%0d", n, early, edges, LAT);
      end
      total++;
      if (d !== exp_block(a)) begin bad++; $display("FAIL random_data[%0d]: got %h expected %h", n, d, exp_block(a)); end
    end
  endtask

`ifdef INS_MEM_READCNT_EN
  task automatic test_read_count();
    bit early; int edges; logic [127:0] d;
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    total++;
    if (read_count !== 16'd0) begin bad++; $display("FAIL rc_reset: got %h expected 0", read_count); end
    run_read(6'h03, 6'h03, 1'b0, early, edges, d);
    run_read(6'h04, 6'h04, 1'b0, early, edges, d);
    @(negedge CLK);
    memread = 1'b1;
    @(posedge CLK);
    memread = 1'b0;
    #2 RESET = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    total++;
    if (read_count !== 16'd0) begin bad++; $display("FAIL rc_abort_clear: got %h expected 0", read_count); end
    run_read(6'h03, 6'h03, 1'b0, early, edges, d);
    run_read(6'h06, 6'h06, 1'b0, early, edges, d);
    total++;
    if (read_count !== 16'd2) begin bad++; $display("FAIL rc_two: got %h expected 2", read_count); end
    @(negedge CLK);
    u_dut.r_read_count <= 16'hFFFE;
    for (int n = 0; n < 3; n++) run_read(6'(n), 6'(n), 1'b0, early, edges, d);
    total++;
    if (read_count !== 16'hFFFF) begin bad++; $display("FAIL rc_saturate: got %h expected ffff", read_count); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 load_image();
    test_reset();
    test_single();
    test_addr_change();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef INS_MEM_READCNT_EN
    test_read_count();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
